// File: rtl/strassen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// strassen_pkg : shared types/constants for the level-1 Strassen Q scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package strassen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    BUSY = 2'd1,
    PEND = 2'd2
  } unit_st_t;

  localparam int NUM_JOBS_DEF = 7;
  localparam int IDXW_DEF     = 3;

endpackage
`default_nettype wire

// File: rtl/strassen_prio_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// strassen_prio_pick : lowest-index-first picker over an N-bit request vector
// Rev 1.0
// ---------------------------------------------------------------------------
module strassen_prio_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [1:0]   idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 2'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/strassen_q_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// strassen_q_scheduler : dispatches Q1..Q7 onto NUM_UNITS level-2 engines and
// serialises their writebacks into the Q bank.  Rev 1.0
// ---------------------------------------------------------------------------
module strassen_q_scheduler
  import strassen_pkg::*;
#(
  parameter int NUM_JOBS  = NUM_JOBS_DEF,
  parameter int NUM_UNITS = 2,
  parameter int IDXW      = IDXW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [NUM_UNITS-1:0]      unit_start,
  output logic [NUM_UNITS*IDXW-1:0] unit_job,
  output logic [IDXW-1:0]           src_sel,
  input  logic [NUM_UNITS-1:0]      unit_done,
  output logic                      q_wr_en,
  output logic [IDXW-1:0]           q_wr_idx,
  output logic [1:0]                q_wr_unit
);

  localparam int              CNTW   = IDXW + 1;
  localparam logic [CNTW-1:0] JOBS_C = CNTW'(NUM_JOBS);

  state_t               state, state_nx;
  unit_st_t             ust   [NUM_UNITS];
  logic [IDXW-1:0]      job_q [NUM_UNITS];
  logic [NUM_UNITS-1:0] stale;
  logic [CNTW-1:0]      issued, written;

  logic                 accept, run_ok, issue_en, wb_en;
  logic                 free_vld, wb_vld;
  logic [1:0]           free_idx, wb_idx;
  logic [NUM_UNITS-1:0] free_vec, wb_req, spur_vec, issue_vec, wb_vec;
  logic [CNTW-1:0]      issued_base, written_base, issued_nx, written_nx;
  logic [IDXW-1:0]      next_job, wb_job;

  // A stale engine was busy when a run was aborted; its late done is dropped.
  always_comb begin
    free_vec = '0;
    wb_req   = '0;
    spur_vec = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      free_vec[u] = (ust[u] == FREE);
      wb_req[u]   = (ust[u] == PEND) ||
                    ((ust[u] == BUSY) && unit_done[u] && !stale[u]);
      spur_vec[u] = unit_done[u] && (ust[u] != BUSY);
    end
  end

  strassen_prio_pick #(.N(NUM_UNITS)) u_pick_free (
    .req   (free_vec),
    .valid (free_vld),
    .idx   (free_idx)
  );

  strassen_prio_pick #(.N(NUM_UNITS)) u_pick_pend (
    .req   (wb_req),
    .valid (wb_vld),
    .idx   (wb_idx)
  );

  always_comb begin
    accept       = (state == IDLE) && start && !abort;
    run_ok       = (state == RUN) && !abort;
    issued_base  = accept ? '0 : issued;
    written_base = accept ? '0 : written;
    next_job     = issued_base[IDXW-1:0];
    issue_en     = free_vld && (accept || run_ok) && (issued_base < JOBS_C);
    wb_en        = wb_vld && run_ok;
    issued_nx    = issued_base + CNTW'(issue_en);
    written_nx   = written_base + CNTW'(wb_en && (written_base < JOBS_C));
    issue_vec    = '0;
    wb_vec       = '0;
    wb_job       = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      issue_vec[u] = issue_en && (free_idx == 2'(u));
      wb_vec[u]    = wb_en && (wb_idx == 2'(u));
      if (wb_idx == 2'(u)) wb_job = job_q[u];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if ((issued == JOBS_C) && (written == JOBS_C)) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        ust[u]   <= FREE;
        job_q[u] <= '0;
      end
      stale <= '0;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        if (issue_vec[u]) begin
          ust[u]   <= BUSY;
          job_q[u] <= next_job;
          stale[u] <= 1'b0;
        end else begin
          case (ust[u])
            BUSY: begin
              if (unit_done[u]) begin
                stale[u] <= 1'b0;
                if (stale[u] || !run_ok || wb_vec[u]) ust[u] <= FREE;
                else                                  ust[u] <= PEND;
              end else if (abort) begin
                stale[u] <= 1'b1;
              end
            end
            PEND:    if (abort || wb_vec[u]) ust[u] <= FREE;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued     <= '0;
      written    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      unit_start <= '0;
      src_sel    <= '0;
      q_wr_en    <= 1'b0;
      q_wr_idx   <= '0;
      q_wr_unit  <= 2'd0;
    end else begin
      issued     <= issued_nx;
      written    <= written_nx;
      busy       <= (state_nx != IDLE);
      done       <= (state_nx == FINISH);
      err        <= (err && !accept) || (|spur_vec);
      unit_start <= issue_vec;
      q_wr_en    <= wb_en;
      if (issue_en) src_sel <= next_job;
      if (wb_en) begin
        q_wr_idx  <= wb_job;
        q_wr_unit <= wb_idx;
      end
    end
  end

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit_job
    assign unit_job[g*IDXW +: IDXW] = job_q[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_strassen_q_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_strassen_q_scheduler : scoreboard bench, two-engine and one-engine DUTs
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_strassen_q_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic unexp(string name, logic [63:0] act);
    n_total++;
    $display("FAIL %s: got %h expected no event (cyc %0d)", name, act, cyc);
  endtask

  // ---------------- DUT A: two engines ----------------
  logic       start_a, abort_a, busy_a, done_a, err_a, q_wr_en_a;
  logic [1:0] unit_start_a, unit_done_a, q_wr_unit_a, inj_a;
  logic [5:0] unit_job_a;
  logic [2:0] src_sel_a, q_wr_idx_a;
  logic [7:0] cnt_a [2];
  int         lat_a [2];

  strassen_q_scheduler #(.NUM_JOBS(7), .NUM_UNITS(2), .IDXW(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .err(err_a),
    .unit_start(unit_start_a), .unit_job(unit_job_a), .src_sel(src_sel_a),
    .unit_done(unit_done_a), .q_wr_en(q_wr_en_a), .q_wr_idx(q_wr_idx_a),
    .q_wr_unit(q_wr_unit_a)
  );

  // Engine model: done pulses lat cycles after the cycle unit_start is seen.
  always @(posedge clk or posedge rst)
    if (rst) begin
      cnt_a[0] <= 8'd0;
      cnt_a[1] <= 8'd0;
    end else begin
      for (int u = 0; u < 2; u++)
        if (unit_start_a[u])    cnt_a[u] <= 8'(lat_a[u]);
        else if (cnt_a[u] != 0) cnt_a[u] <= cnt_a[u] - 8'd1;
    end
  assign unit_done_a = {cnt_a[1] == 8'd1, cnt_a[0] == 8'd1} | inj_a;

  // ---------------- DUT B: single engine ----------------
  logic       start_b, abort_b, busy_b, done_b, err_b, q_wr_en_b;
  logic [0:0] unit_start_b, unit_done_b;
  logic [1:0] q_wr_unit_b;
  logic [2:0] unit_job_b, src_sel_b, q_wr_idx_b;
  logic [7:0] cnt_b;

  strassen_q_scheduler #(.NUM_JOBS(7), .NUM_UNITS(1), .IDXW(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .err(err_b),
    .unit_start(unit_start_b), .unit_job(unit_job_b), .src_sel(src_sel_b),
    .unit_done(unit_done_b), .q_wr_en(q_wr_en_b), .q_wr_idx(q_wr_idx_b),
    .q_wr_unit(q_wr_unit_b)
  );

  always @(posedge clk or posedge rst)
    if (rst)                cnt_b <= 8'd0;
    else if (unit_start_b)  cnt_b <= 8'd5;
    else if (cnt_b != 0)    cnt_b <= cnt_b - 8'd1;
  assign unit_done_b = (cnt_b == 8'd1);

  // ---------------- scoreboards ----------------
  // start event: {cycle, unit_start vector, src_sel, unit_job of that unit}
  // writeback event: {cycle, q_wr_idx, q_wr_unit, 0}; done event: {cycle, 0}
  logic [63:0] exp_st_a[$], exp_wr_a[$], exp_dn_a[$];
  logic [63:0] exp_st_b[$], exp_wr_b[$], exp_dn_b[$];

  always @(negedge clk) if (!rst) begin : mon_a
    logic [63:0] act;
    if (unit_start_a != 2'b00) begin
      act = {32'(cyc), 8'(unit_start_a), 8'(src_sel_a),
             16'(unit_start_a[0] ? unit_job_a[2:0] : unit_job_a[5:3])};
      if (exp_st_a.size() == 0) unexp("start_a", act);
      else chk("start_a", act, exp_st_a.pop_front());
    end
    if (q_wr_en_a) begin
      act = {32'(cyc), 8'(q_wr_idx_a), 8'(q_wr_unit_a), 16'd0};
      if (exp_wr_a.size() == 0) unexp("wr_a", act);
      else chk("wr_a", act, exp_wr_a.pop_front());
    end
    if (done_a) begin
      act = {32'(cyc), 32'd0};
      if (exp_dn_a.size() == 0) unexp("done_a", act);
      else chk("done_a", act, exp_dn_a.pop_front());
    end
  end

  always @(negedge clk) if (!rst) begin : mon_b
    logic [63:0] act;
    if (unit_start_b != 1'b0) begin
      act = {32'(cyc), 8'(unit_start_b), 8'(src_sel_b), 16'(unit_job_b)};
      if (exp_st_b.size() == 0) unexp("start_b", act);
      else chk("start_b", act, exp_st_b.pop_front());
    end
    if (q_wr_en_b) begin
      act = {32'(cyc), 8'(q_wr_idx_b), 8'(q_wr_unit_b), 16'd0};
      if (exp_wr_b.size() == 0) unexp("wr_b", act);
      else chk("wr_b", act, exp_wr_b.pop_front());
    end
    if (done_b) begin
      act = {32'(cyc), 32'd0};
      if (exp_dn_b.size() == 0) unexp("done_b", act);
      else chk("done_b", act, exp_dn_b.pop_front());
    end
  end

  // Hand-derived event cycles relative to the cycle start is sampled.
  // Mode 1: both engines latency 5.  Mode 2: engine0 latency 6, engine1 5,
  // so both engines finish in the same cycle.  Job j lands on unit j%2.
  int t1_st [7] = '{1, 2, 8, 9, 15, 16, 22};
  int t1_wr [7] = '{7, 8, 14, 15, 21, 22, 28};
  int t2_st [7] = '{1, 2, 9, 10, 17, 18, 25};
  int t2_wr [7] = '{8, 9, 16, 17, 24, 25, 32};

  task automatic push_a(int base, int mode, int n_st, int n_wr, bit with_done);
    for (int j = 0; j < n_st; j++) begin
      int c = (mode == 2) ? t2_st[j] : t1_st[j];
      exp_st_a.push_back({32'(base + c), 8'(1 << (j % 2)), 8'(j), 16'(j)});
    end
    for (int j = 0; j < n_wr; j++) begin
      int c = (mode == 2) ? t2_wr[j] : t1_wr[j];
      exp_wr_a.push_back({32'(base + c), 8'(j), 8'(j % 2), 16'd0});
    end
    if (with_done) exp_dn_a.push_back({32'(base + ((mode == 2) ? 33 : 29)), 32'd0});
  endtask

  task automatic launch_a(int mode, int n_st, int n_wr, bit with_done, output int base);
    @(negedge clk);
    base = cyc;
    push_a(base, mode, n_st, n_wr, with_done);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic drain_a(string tag, int budget);
    int k = 0;
    while ((exp_st_a.size() + exp_wr_a.size() + exp_dn_a.size() != 0 || busy_a) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_total++;
      $display("FAIL %s: timeout with %0d events outstanding, busy=%0b", tag,
               exp_st_a.size() + exp_wr_a.size() + exp_dn_a.size(), busy_a);
      exp_st_a.delete(); exp_wr_a.delete(); exp_dn_a.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; inj_a = 2'b00;
    start_b = 1'b0; abort_b = 1'b0;
    lat_a = '{5, 5};
    repeat (3) @(negedge clk);
    chk("reset_ctl_a", 64'({busy_a, done_a, err_a, q_wr_en_a}), 64'd0);
    chk("reset_vec_a", 64'({unit_start_a, unit_job_a, src_sel_a, q_wr_idx_a, q_wr_unit_a}), 64'd0);
    chk("reset_b", 64'({busy_b, done_b, err_b, q_wr_en_b, unit_start_b, unit_job_b,
                        src_sel_b, q_wr_idx_b, q_wr_unit_b}), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal run, latency 5 on both engines.
    launch_a(1, 7, 7, 1'b1, base);
    chk("busy_after_start", 64'(busy_a), 64'd1);
    drain_a("nominal", 100);
    chk("err_nominal", 64'(err_a), 64'd0);

    // Simultaneous completion on both engines.
    lat_a = '{6, 5};
    launch_a(2, 7, 7, 1'b1, base);
    drain_a("simul_done", 100);
    lat_a = '{5, 5};

    // Abort in the cycle of the 3rd writeback.
    launch_a(1, 4, 3, 1'b0, base);
    while (cyc < base + 14) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort_idle", 64'(busy_a), 64'd0);
    drain_a("abort", 40);
    launch_a(1, 7, 7, 1'b1, base);
    drain_a("after_abort", 100);

    // Spurious done on an idle engine.
    @(negedge clk);
    inj_a = 2'b10;
    @(negedge clk);
    inj_a = 2'b00;
    chk("err_set", 64'(err_a), 64'd1);
    repeat (5) @(negedge clk);
    chk("err_sticky", 64'(err_a), 64'd1);
    launch_a(1, 7, 7, 1'b1, base);
    chk("err_cleared", 64'(err_a), 64'd0);
    drain_a("after_err", 100);

    // start held high: second run launched from the IDLE cycle after done.
    @(negedge clk);
    base = cyc;
    push_a(base, 1, 7, 7, 1'b1);
    push_a(base + 30, 1, 7, 7, 1'b1);
    start_a = 1'b1;
    while (cyc < base + 30) @(negedge clk);
    chk("held_start_idle", 64'(busy_a), 64'd0);
    @(negedge clk);
    start_a = 1'b0;
    drain_a("held_start", 100);

    // Single engine: strictly serial, each job 7 cycles after the last.
    @(negedge clk);
    base = cyc;
    for (int k = 0; k < 7; k++) begin
      exp_st_b.push_back({32'(base + 1 + 7 * k), 8'd1, 8'(k), 16'(k)});
      exp_wr_b.push_back({32'(base + 7 + 7 * k), 8'(k), 8'd0, 16'd0});
    end
    exp_dn_b.push_back({32'(base + 50), 32'd0});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    begin
      int k = 0;
      while ((exp_st_b.size() + exp_wr_b.size() + exp_dn_b.size() != 0 || busy_b) && k < 150) begin
        @(negedge clk);
        k++;
      end
      if (k >= 150) begin
        n_total++;
        $display("FAIL serial: timeout with %0d events outstanding",
                 exp_st_b.size() + exp_wr_b.size() + exp_dn_b.size());
      end
    end
    repeat (6) @(negedge clk);
    chk("err_serial", 64'(err_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/strassen_q_scheduler.md
# strassen_q_scheduler

Sequencing controller that dispatches the seven level-1 Strassen products (Q1..Q7 = Ti·Si) onto a pool of NUM_UNITS shared level-2 multiplier engines. It sits between the level-1 T/S/Q register banks and the engines. It drives the operand-select mux and per-engine start pulses, collects per-engine done pulses, and serialises Q writebacks into the Q bank. It raises a single done pulse when all seven products are stored.

## Interface
- NUM_JOBS, 7: number of products to schedule; jobs 0..NUM_JOBS-1 map to Q1..Q7.
- NUM_UNITS, 2: number of level-2 engines; range 1..4.
- IDXW, 3: job-index width; requires 2^IDXW ≥ NUM_JOBS.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level/pulse; sampled only in IDLE.
- abort  in  1  sampled every cycle; abandons the run.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when all jobs are written back.
- err  out  1  sticky spurious-done flag; cleared by rst or by an accepted start.
- unit_start  out  NUM_UNITS  one-cycle start pulse per engine.
- unit_job  out  NUM_UNITS*IDXW  job index owned by each engine; held from start until writeback.
- src_sel  out  IDXW  T/S operand mux select; valid in the cycle its unit_start is high.
- unit_done  in  NUM_UNITS  one-cycle completion pulse per engine. The engine's Q output stays stable until its next start.
- q_wr_en  out  1  Q-bank write strobe.
- q_wr_idx  out  IDXW  destination slot (job index).
- q_wr_unit  out  2  engine whose Q output is captured.

## Operation
- States:
  - IDLE → RUN on start. Accepting start clears the counters and err.
  - RUN → FINISH when issued == NUM_JOBS and written == NUM_JOBS.
  - FINISH → IDLE unconditionally; done = 1 in FINISH.
  - abort in any state → IDLE next cycle. No done pulse. Pending writebacks are discarded and unit_start is suppressed. Engine state is not reset.
- Per-engine status is one of FREE, BUSY, or PEND (done received, writeback outstanding). An engine is issuable only when FREE.
- Dispatch:
  - At most one issue per cycle, in strict job order 0,1,…,NUM_JOBS-1.
  - The target is the lowest-indexed FREE engine.
  - Issue sets the engine to BUSY, loads unit_job, and increments issued.
- Completion:
  - unit_done[u] while BUSY → PEND.
  - unit_done[u] while FREE or PEND sets err and is otherwise ignored.
- Writeback:
  - One per cycle, taken from the lowest-indexed PEND engine. It drives q_wr_idx = unit_job[u] and q_wr_unit = u.
  - The engine returns to FREE and written is incremented.
  - An engine freed by writeback in cycle t is issuable in cycle t+1.
- start while busy is ignored.
- Counters are IDXW+1 bits wide and saturate at NUM_JOBS; they never wrap.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, unit_start 0, unit_job 0, src_sel 0, q_wr_en 0, q_wr_idx 0, q_wr_unit 0, all engines FREE.
- All outputs are registered.
- Start latency:
  - start high in IDLE at cycle 0 → busy and the first unit_start at cycle 1.
  - Further issues follow at cycles 2, 3, … while engines are FREE.
- Completion latency: unit_done at cycle t → q_wr_en at cycle t+1 at the earliest. Each extra PEND engine ahead in priority adds one cycle.
- done is high in the cycle after the last q_wr_en. busy drops in the cycle after done.
- Simultaneous events:
  - A done pulse and a writeback on different engines in the same cycle are both processed.
  - A writeback and an issue can occur in the same cycle, but never to the same engine.
- abort asserted in the same cycle as start in IDLE: abort wins and the FSM stays in IDLE.

## Structure
- Shared package strassen_pkg holds:
  - the state enum {IDLE, RUN, FINISH};
  - the unit-status enum {FREE, BUSY, PEND};
  - the constants NUM_JOBS_DEF = 7 and IDXW_DEF = 3.
- One sub-module, strassen_prio_pick: a lowest-index-first picker over an NUM_UNITS-bit request vector returning valid and index. It is instantiated twice, once for the FREE set and once for the PEND set.

## Test plan
- NUM_UNITS=2, every engine returns done 5 cycles after start, start at cycle 0 → issues of jobs 0/1 at cycles 1/2. All seven q_wr_idx values 0..6 are written exactly once. done pulses once; err = 0.
- Both engines pulse unit_done in the same cycle → q_wr_en on two consecutive cycles, unit 0 first then unit 1. The correct job indices appear on q_wr_idx.
- NUM_UNITS=1 → strictly serial issue. Each unit_start occurs one cycle after the previous q_wr_en. q_wr_idx sequence is 0..6.
- abort asserted after the 3rd writeback → IDLE next cycle, no done, no further unit_start or q_wr_en. A following start runs the full 0..6 sequence.
- unit_done pulsed on an idle engine → err = 1 and stays set; there is no spurious q_wr_en. The next accepted start clears err.
- start held high throughout a run → ignored while busy. A new run begins the cycle after returning to IDLE.
